// File: rtl/alu1_pkg.sv
// alu1_pkg
// Shared definitions for the ALU1 arbiter slice.
//   ALU1_CMD_WIDTH : width of the ALU1 command field
//   Alu1Op         : ALU1 operation encoding carried on req_cmd / alu_cmd
//   alu1_tag_width : width of a requester index (tag) for a given NREQ
// The tag type itself (alu1_tag_t) is declared inside each arbiter instance
// from alu1_tag_width(NREQ), because its width depends on the instance's NREQ.
package alu1_pkg;

    localparam int ALU1_CMD_WIDTH = 4;

    typedef enum logic [ALU1_CMD_WIDTH-1:0] {
        ALU1_ADD  = 4'd0,
        ALU1_SUB  = 4'd1,
        ALU1_AND  = 4'd2,
        ALU1_OR   = 4'd3,
        ALU1_XOR  = 4'd4,
        ALU1_SHL  = 4'd5,
        ALU1_SHR  = 4'd6,
        ALU1_PASS = 4'd7
    } Alu1Op;

    // Never returns less than one bit, so a tag register always exists.
    function automatic int alu1_tag_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/alu1_rr_picker.sv
// alu1_rr_picker
// Combinational round-robin picker. Starting at index ptr and walking
// upward modulo NREQ, the first asserted req bit wins.
// Ports:
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  index with the highest priority this cycle
//   grant out NREQ   one-hot grant, zero when no request is set
//   idx   out IDX_W  index of the granted requester (0 when none)
//   found out 1      some requester was granted
module alu1_rr_picker
    import alu1_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk the ring starting at ptr; once a winner is found later
    // candidates are ignored, which keeps the grant one-hot.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos     = (int'(ptr) + i) % NREQ;
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found          = 1'b1;
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/alu1_arbiter.sv
// alu1_arbiter
// Shares one ALU1 among NREQ requesters. A round-robin grant picks one
// requester per cycle, its command/operands are registered onto the ALU1
// inputs, and a tag pipeline matched to the ALU1 latency routes the result
// back to the issuing requester one cycle after ALU1 produces it.
// Optional feature macro: ALU1_ARB_LOCK_EN (adds req_lock and grant locking).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready is the grant)
//   req_cmd, req_in1/2  per-requester command and operands
//   req_lock            hold grant for the next op (ALU1_ARB_LOCK_EN only)
//   rsp_valid           one-hot response strobe
//   rsp_out, rsp_co     response result and carry
//   alu_cmd, alu_in1/2  registered command/operands to ALU1
//   alu_out, alu_co     ALU1 result and carry
module alu1_arbiter
    import alu1_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NREQ    = 4,
    parameter int LATENCY = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ-1:0][ALU1_CMD_WIDTH-1:0]  req_cmd,
    input  logic [NREQ-1:0][WIDTH-1:0]           req_in1,
    input  logic [NREQ-1:0][WIDTH-1:0]           req_in2,
`ifdef ALU1_ARB_LOCK_EN
    input  logic [NREQ-1:0]                      req_lock,
`endif
    output logic [NREQ-1:0]                      rsp_valid,
    output logic [WIDTH-1:0]                     rsp_out,
    output logic                                 rsp_co,
    output logic [ALU1_CMD_WIDTH-1:0]            alu_cmd,
    output logic [WIDTH-1:0]                     alu_in1,
    output logic [WIDTH-1:0]                     alu_in2,
    input  logic [WIDTH-1:0]                     alu_out,
    input  logic                                 alu_co
);

    localparam int TAG_W = alu1_tag_width(NREQ);

    typedef logic [TAG_W-1:0] alu1_tag_t;

    localparam alu1_tag_t       LAST_IDX = alu1_tag_t'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    alu1_tag_t       rr_ptr;
    logic [NREQ-1:0] pick_grant;
    alu1_tag_t       pick_idx;
    logic            pick_found;

    logic [NREQ-1:0] grant;
    alu1_tag_t       grant_idx;
    logic            fire;

    // Stage 0 is the issue stage (valid in the cycle alu_* is driven);
    // stage LATENCY lines up with the cycle ALU1 presents that op's result.
    logic [LATENCY:0] pipe_vld;
    alu1_tag_t        pipe_tag [LATENCY+1];

    alu1_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (TAG_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef ALU1_ARB_LOCK_EN
    logic      lock_active;
    alu1_tag_t lock_owner;
    logic      lock_hold;

    assign lock_hold = lock_active && req_valid[lock_owner] && req_lock[lock_owner];

    // A held lock overrides round-robin; reset masks every grant.
    always_comb begin
        grant     = '0;
        grant_idx = pick_idx;
        fire      = 1'b0;
        if (rst) begin
            grant = '0;
            fire  = 1'b0;
        end else if (lock_hold) begin
            grant[lock_owner] = 1'b1;
            grant_idx         = lock_owner;
            fire              = 1'b1;
        end else begin
            grant = pick_grant;
            fire  = pick_found;
        end
    end

    // Lock is (re)taken by any handshake with req_lock set and dropped the
    // first cycle the owner stops holding valid+lock. rr_ptr already points
    // past the owner, so round-robin resumes from owner+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (fire && req_lock[grant_idx]) begin
            lock_active <= 1'b1;
            lock_owner  <= grant_idx;
        end else if (lock_active && !lock_hold) begin
            lock_active <= 1'b0;
        end
    end
`else
    // Pure round-robin; reset masks every grant.
    always_comb begin
        grant     = rst ? '0 : pick_grant;
        grant_idx = pick_idx;
        fire      = !rst && pick_found;
    end
`endif

    assign req_ready = grant;

    // Issue registers, round-robin pointer and tag pipeline. ALU1 inputs
    // hold their last values between handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_cmd  <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            rr_ptr   <= '0;
            pipe_vld <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                pipe_tag[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
            pipe_vld[0] <= fire;
            if (fire) begin
                alu_cmd     <= req_cmd[grant_idx];
                alu_in1     <= req_in1[grant_idx];
                alu_in2     <= req_in2[grant_idx];
                pipe_tag[0] <= grant_idx;
                rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + alu1_tag_t'(1);
            end
        end
    end

    // Response registers capture ALU1 output when the matching tag emerges;
    // bubbles leave rsp_valid low and keep the previous data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_out   <= '0;
            rsp_co    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pipe_vld[LATENCY]) begin
                rsp_valid <= ONE_HOT0 << pipe_tag[LATENCY];
                rsp_out   <= alu_out;
                rsp_co    <= alu_co;
            end
        end
    end

endmodule

// File: tb/tb_alu1_arbiter.sv
// tb_alu1_arbiter
// Scoreboard bench for alu1_arbiter. Two instances share clock and reset:
// dut_a with LATENCY=0 and dut_b with LATENCY=3, each fed by a small ALU1
// model. Expected responses are queued when a grant is expected and popped
// by per-instance monitors when rsp_valid rises.
// Lock scenario is compiled only with ALU1_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_alu1_arbiter;
    import alu1_pkg::*;

    localparam int WIDTH = 64;
    localparam int NREQ  = 4;
    localparam int LAT_B = 3;

    typedef struct {
        logic [NREQ-1:0]  vld;
        logic [WIDTH-1:0] out;
        logic             co;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    logic [NREQ-1:0]                     valid_a, ready_a, rsp_valid_a;
    logic [NREQ-1:0][ALU1_CMD_WIDTH-1:0] cmd_a;
    logic [NREQ-1:0][WIDTH-1:0]          in1_a, in2_a;
    logic [NREQ-1:0]                     lock_a;
    logic [WIDTH-1:0]                    rsp_out_a, alu_in1_a, alu_in2_a, alu_out_a;
    logic                                rsp_co_a, alu_co_a;
    logic [ALU1_CMD_WIDTH-1:0]           alu_cmd_a;

    logic [NREQ-1:0]                     valid_b, ready_b, rsp_valid_b;
    logic [NREQ-1:0][ALU1_CMD_WIDTH-1:0] cmd_b;
    logic [NREQ-1:0][WIDTH-1:0]          in1_b, in2_b;
    logic [NREQ-1:0]                     lock_b;
    logic [WIDTH-1:0]                    rsp_out_b, alu_in1_b, alu_in2_b, alu_out_b;
    logic                                rsp_co_b, alu_co_b;
    logic [ALU1_CMD_WIDTH-1:0]           alu_cmd_b;

    logic [WIDTH:0] d1_b, d2_b, d3_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH:0] alu_model(input logic [ALU1_CMD_WIDTH-1:0] cmd,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (cmd)
            ALU1_ADD: r = {1'b0, a} + {1'b0, b};
            ALU1_SUB: r = {1'b0, a} - {1'b0, b};
            ALU1_AND: r = {1'b0, a & b};
            ALU1_OR:  r = {1'b0, a | b};
            default:  r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    // ALU1 models: combinational for dut_a, three register stages for dut_b.
    assign {alu_co_a, alu_out_a} = alu_model(alu_cmd_a, alu_in1_a, alu_in2_a);

    always @(posedge clk) begin
        d1_b <= alu_model(alu_cmd_b, alu_in1_b, alu_in2_b);
        d2_b <= d1_b;
        d3_b <= d2_b;
    end
    assign {alu_co_b, alu_out_b} = d3_b;

    alu1_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid_a),
        .req_ready (ready_a),
        .req_cmd   (cmd_a),
        .req_in1   (in1_a),
        .req_in2   (in2_a),
`ifdef ALU1_ARB_LOCK_EN
        .req_lock  (lock_a),
`endif
        .rsp_valid (rsp_valid_a),
        .rsp_out   (rsp_out_a),
        .rsp_co    (rsp_co_a),
        .alu_cmd   (alu_cmd_a),
        .alu_in1   (alu_in1_a),
        .alu_in2   (alu_in2_a),
        .alu_out   (alu_out_a),
        .alu_co    (alu_co_a)
    );

    alu1_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LAT_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (valid_b),
        .req_ready (ready_b),
        .req_cmd   (cmd_b),
        .req_in1   (in1_b),
        .req_in2   (in2_b),
`ifdef ALU1_ARB_LOCK_EN
        .req_lock  (lock_b),
`endif
        .rsp_valid (rsp_valid_b),
        .rsp_out   (rsp_out_b),
        .rsp_co    (rsp_co_b),
        .alu_cmd   (alu_cmd_b),
        .alu_in1   (alu_in1_b),
        .alu_in2   (alu_in2_b),
        .alu_out   (alu_out_b),
        .alu_co    (alu_co_b)
    );

    // Response monitors: every rsp_valid must match the oldest expectation,
    // including the cycle it was due.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (mon_on && rsp_valid_a !== '0) begin
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp_a_unexpected got valid=%b expected none", rsp_valid_a);
            end else begin
                e = sb_a.pop_front();
                if (rsp_valid_a !== e.vld || rsp_out_a !== e.out || rsp_co_a !== e.co || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL rsp_a got valid=%b out=%h co=%b cyc=%0d expected valid=%b out=%h co=%b cyc=%0d",
                             rsp_valid_a, rsp_out_a, rsp_co_a, cyc, e.vld, e.out, e.co, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (mon_on && rsp_valid_b !== '0) begin
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp_b_unexpected got valid=%b expected none", rsp_valid_b);
            end else begin
                e = sb_b.pop_front();
                if (rsp_valid_b !== e.vld || rsp_out_b !== e.out || rsp_co_b !== e.co || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL rsp_b got valid=%b out=%h co=%b cyc=%0d expected valid=%b out=%h co=%b cyc=%0d",
                             rsp_valid_b, rsp_out_b, rsp_co_b, cyc, e.vld, e.out, e.co, e.due);
                end
            end
        end
    end

    // Queue the response expected for a handshake happening this cycle.
    task automatic expect_rsp(input bit on_b, input int g,
                              input logic [ALU1_CMD_WIDTH-1:0] cmd,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t           e;
        logic [WIDTH:0] r;
        r     = alu_model(cmd, a, b);
        e.vld = 4'b0001 << g;
        e.out = r[WIDTH-1:0];
        e.co  = r[WIDTH];
        e.due = cyc + (on_b ? LAT_B : 0) + 2;
        if (on_b) sb_b.push_back(e);
        else      sb_a.push_back(e);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst     = 1'b1;
        valid_a = 4'b1111;
        valid_b = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b0000) begin
            errors++; $display("[TB] FAIL ready_a_in_reset got %b expected 0000", ready_a);
        end
        checks++;
        if (ready_b !== 4'b0000) begin
            errors++; $display("[TB] FAIL ready_b_in_reset got %b expected 0000", ready_b);
        end
        checks++;
        if (rsp_valid_a !== '0 || rsp_out_a !== '0 || rsp_co_a !== 1'b0) begin
            errors++; $display("[TB] FAIL rsp_a_reset got %b/%h/%b expected 0/0/0", rsp_valid_a, rsp_out_a, rsp_co_a);
        end
        checks++;
        if (alu_cmd_a !== '0 || alu_in1_a !== '0 || alu_in2_a !== '0) begin
            errors++; $display("[TB] FAIL alu_a_reset got %h/%h/%h expected 0/0/0", alu_cmd_a, alu_in1_a, alu_in2_a);
        end
        checks++;
        if (rsp_valid_b !== '0 || rsp_out_b !== '0 || rsp_co_b !== 1'b0) begin
            errors++; $display("[TB] FAIL rsp_b_reset got %b/%h/%b expected 0/0/0", rsp_valid_b, rsp_out_b, rsp_co_b);
        end
        valid_a = 4'b0110;
        valid_b = 4'b0000;
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b0010) begin
            errors++; $display("[TB] FAIL ready_after_reset got %b expected 0010", ready_a);
        end
        valid_a = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int c;
        $display("[TB] test_single");
        valid_a  = 4'b0100;
        cmd_a[2] = ALU1_ADD;
        in1_a[2] = {WIDTH{1'b1}};
        in2_a[2] = 64'd1;
        @(negedge clk);
        c = cyc;
        checks++;
        if (ready_a !== 4'b0100) begin
            errors++; $display("[TB] FAIL single_grant got %b expected 0100", ready_a);
        end
        sb_a.push_back('{vld: 4'b0100, out: 64'd0, co: 1'b1, due: c + 2});
        @(posedge clk); #1;
        valid_a  = 4'b0000;
        in1_a[2] = 64'h1234;
        @(negedge clk);
        checks++;
        if (alu_cmd_a !== ALU1_ADD || alu_in1_a !== {WIDTH{1'b1}} || alu_in2_a !== 64'd1) begin
            errors++; $display("[TB] FAIL single_issue got %h/%h/%h expected 0/ffffffffffffffff/1", alu_cmd_a, alu_in1_a, alu_in2_a);
        end
        @(negedge clk);
        checks++;
        if (alu_in1_a !== {WIDTH{1'b1}}) begin
            errors++; $display("[TB] FAIL alu_hold got %h expected ffffffffffffffff", alu_in1_a);
        end
        for (int w = 0; w < 20 && sb_a.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb_a.size() != 0) begin
            errors++; $display("[TB] FAIL single_drain pending=%0d expected 0", sb_a.size());
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        $display("[TB] test_round_robin");
        pulse_reset();
        valid_a = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                cmd_a[r] = 4'((k + r) % 5);
                in1_a[r] = {$urandom(), $urandom()};
                in2_a[r] = {$urandom(), $urandom()};
            end
            @(negedge clk);
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (ready_a !== exp_g) begin
                errors++; $display("[TB] FAIL rr_grant%0d got %b expected %b", k, ready_a, exp_g);
            end
            expect_rsp(1'b0, k % 4, cmd_a[k % 4], in1_a[k % 4], in2_a[k % 4]);
            @(posedge clk); #1;
        end
        valid_a = 4'b0000;
        for (int w = 0; w < 20 && sb_a.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb_a.size() != 0) begin
            errors++; $display("[TB] FAIL rr_drain pending=%0d expected 0", sb_a.size());
        end
    endtask

    task automatic test_latency3();
        int              g;
        logic [NREQ-1:0] exp_g;
        $display("[TB] test_latency3");
        for (int k = 0; k < 6; k++) begin
            g        = (k % 2 == 0) ? 1 : 3;
            exp_g    = 4'b0001 << g;
            valid_b  = exp_g;
            cmd_b[g] = 4'(k % 5);
            in1_b[g] = {$urandom(), $urandom()};
            in2_b[g] = {$urandom(), $urandom()};
            @(negedge clk);
            checks++;
            if (ready_b !== exp_g) begin
                errors++; $display("[TB] FAIL lat3_grant%0d got %b expected %b", k, ready_b, exp_g);
            end
            expect_rsp(1'b1, g, cmd_b[g], in1_b[g], in2_b[g]);
            @(posedge clk); #1;
        end
        valid_b = 4'b0000;
        for (int w = 0; w < 20 && sb_b.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb_b.size() != 0) begin
            errors++; $display("[TB] FAIL lat3_drain pending=%0d expected 0", sb_b.size());
        end
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        pulse_reset();
        valid_a  = 4'b0100;
        cmd_a[2] = ALU1_OR;
        in1_a[2] = 64'h00F0;
        in2_a[2] = 64'h0F00;
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b0100) begin
            errors++; $display("[TB] FAIL wrap_setup got %b expected 0100", ready_a);
        end
        expect_rsp(1'b0, 2, cmd_a[2], in1_a[2], in2_a[2]);
        @(posedge clk); #1;
        valid_a  = 4'b1001;
        cmd_a[0] = ALU1_SUB;
        in1_a[0] = 64'd5;
        in2_a[0] = 64'd7;
        cmd_a[3] = ALU1_ADD;
        in1_a[3] = 64'h8000_0000_0000_0000;
        in2_a[3] = 64'h8000_0000_0000_0001;
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b1000) begin
            errors++; $display("[TB] FAIL wrap_grant3 got %b expected 1000", ready_a);
        end
        expect_rsp(1'b0, 3, cmd_a[3], in1_a[3], in2_a[3]);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b0001) begin
            errors++; $display("[TB] FAIL wrap_grant0 got %b expected 0001", ready_a);
        end
        expect_rsp(1'b0, 0, cmd_a[0], in1_a[0], in2_a[0]);
        @(posedge clk); #1;
        valid_a = 4'b0000;
        for (int w = 0; w < 20 && sb_a.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb_a.size() != 0) begin
            errors++; $display("[TB] FAIL wrap_drain pending=%0d expected 0", sb_a.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] exp_g;
        $display("[TB] test_reset_mid");
        pulse_reset();
        valid_b = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            in1_b[k] = {$urandom(), $urandom()};
            in2_b[k] = {$urandom(), $urandom()};
            cmd_b[k] = ALU1_XOR;
            @(negedge clk);
            exp_g = 4'b0001 << k;
            checks++;
            if (ready_b !== exp_g) begin
                errors++; $display("[TB] FAIL mid_grant%0d got %b expected %b", k, ready_b, exp_g);
            end
            @(posedge clk); #1;
        end
        rst     = 1'b1;
        valid_b = 4'b1111;
        @(negedge clk);
        checks++;
        if (ready_b !== 4'b0000) begin
            errors++; $display("[TB] FAIL mid_ready_in_reset got %b expected 0000", ready_b);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        valid_b = 4'b1010;
        @(negedge clk);
        checks++;
        if (ready_b !== 4'b0010) begin
            errors++; $display("[TB] FAIL mid_grant_after_reset got %b expected 0010", ready_b);
        end
        checks++;
        if (rsp_valid_b !== 4'b0000) begin
            errors++; $display("[TB] FAIL mid_rsp_after_reset got %b expected 0000", rsp_valid_b);
        end
        valid_b = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_b !== 4'b0000) begin
                errors++; $display("[TB] FAIL mid_rsp_quiet%0d got %b expected 0000", k, rsp_valid_b);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef ALU1_ARB_LOCK_EN
    task automatic test_lock();
        int              seq [5] = '{0, 1, 1, 1, 1};
        logic [NREQ-1:0] exp_g;
        $display("[TB] test_lock");
        pulse_reset();
        valid_a = 4'b0111;
        lock_a  = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                cmd_a[r] = ALU1_ADD;
                in1_a[r] = {$urandom(), $urandom()};
                in2_a[r] = {$urandom(), $urandom()};
            end
            @(negedge clk);
            exp_g = 4'b0001 << seq[k];
            checks++;
            if (ready_a !== exp_g) begin
                errors++; $display("[TB] FAIL lock_grant%0d got %b expected %b", k, ready_a, exp_g);
            end
            expect_rsp(1'b0, seq[k], cmd_a[seq[k]], in1_a[seq[k]], in2_a[seq[k]]);
            @(posedge clk); #1;
        end
        valid_a = 4'b0101;
        lock_a  = 4'b0000;
        @(negedge clk);
        checks++;
        if (ready_a !== 4'b0100) begin
            errors++; $display("[TB] FAIL lock_release got %b expected 0100", ready_a);
        end
        expect_rsp(1'b0, 2, cmd_a[2], in1_a[2], in2_a[2]);
        @(posedge clk); #1;
        valid_a = 4'b0000;
        for (int w = 0; w < 20 && sb_a.size() != 0; w++) @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb_a.size() != 0) begin
            errors++; $display("[TB] FAIL lock_drain pending=%0d expected 0", sb_a.size());
        end
    endtask
`endif

    initial begin
        valid_a = '0; cmd_a = '0; in1_a = '0; in2_a = '0; lock_a = '0;
        valid_b = '0; cmd_b = '0; in1_b = '0; in2_b = '0; lock_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_latency3();
        test_wrap();
        test_reset_mid();
`ifdef ALU1_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
